// File: rtl/fu_complete_arbiter.sv
// FU completion arbiter: per-FU 2-entry FIFOs, round-robin pick, registered CDB broadcast.
// Define FU_COMPLETE_ARBITER_BYPASS_EN to let an empty FIFO's incoming packet win in the same cycle.
module fu_complete_arbiter #(
  parameter int NUM_FU     = 6,
  parameter int XLEN       = 32,
  parameter int PR_W       = 6,
  parameter int ROB_W      = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        squash,
  input  logic [NUM_FU-1:0]                           fu_valid,
  input  logic [NUM_FU*PR_W-1:0]                      fu_pr_idx,
  input  logic [NUM_FU*XLEN-1:0]                      fu_value,
  input  logic [NUM_FU*ROB_W-1:0]                     fu_rob_idx,
  output logic [NUM_FU-1:0]                           fu_ready,
  output logic                                        cdb_valid,
  output logic [PR_W-1:0]                             cdb_pr_idx,
  output logic [XLEN-1:0]                             cdb_value,
  output logic [ROB_W-1:0]                            cdb_rob_idx,
  output logic [$clog2(NUM_FU)-1:0]                   cdb_fu_id,
  output logic [NUM_FU*($clog2(FIFO_DEPTH)+1)-1:0]    occupancy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ID_W  = $clog2(NUM_FU);

  logic [PR_W-1:0]  mem_pr  [NUM_FU][FIFO_DEPTH];
  logic [XLEN-1:0]  mem_val [NUM_FU][FIFO_DEPTH];
  logic [ROB_W-1:0] mem_rob [NUM_FU][FIFO_DEPTH];

  logic [CNT_W-1:0] count [NUM_FU];
  logic [PTR_W-1:0] head  [NUM_FU];
  logic [PTR_W-1:0] tail  [NUM_FU];
  logic [ID_W-1:0]  rr_ptr;

  logic [NUM_FU-1:0] cand;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;
  logic              grant_valid;
  logic [ID_W-1:0]   grant_id;
  logic              win_bypass;
  logic [PR_W-1:0]   win_pr;
  logic [XLEN-1:0]   win_val;
  logic [ROB_W-1:0]  win_rob;

  for (genvar g = 0; g < NUM_FU; g++) begin : g_occ
    assign occupancy[g*CNT_W +: CNT_W] = count[g];
  end

  // Ready comes only from registered counts, so fu_valid never feeds back into fu_ready.
  always_comb begin
    fu_ready = '0;
    cand     = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      fu_ready[i] = reset && (count[i] != CNT_W'(FIFO_DEPTH));
`ifdef FU_COMPLETE_ARBITER_BYPASS_EN
      cand[i] = (count[i] != '0) || (fu_valid[i] && fu_ready[i] && !squash);
`else
      cand[i] = (count[i] != '0);
`endif
    end
  end

  always_comb begin
    int j;
    grant_valid = 1'b0;
    grant_id    = '0;
    j           = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_FU) j = j - NUM_FU;
      if (!grant_valid && cand[j]) begin
        grant_valid = 1'b1;
        grant_id    = ID_W'(j);
      end
    end
  end

  always_comb begin
    win_bypass = 1'b0;
    win_pr     = mem_pr[grant_id][head[grant_id]];
    win_val    = mem_val[grant_id][head[grant_id]];
    win_rob    = mem_rob[grant_id][head[grant_id]];
`ifdef FU_COMPLETE_ARBITER_BYPASS_EN
    if (count[grant_id] == '0) begin
      win_bypass = 1'b1;
      win_pr     = fu_pr_idx[grant_id*PR_W +: PR_W];
      win_val    = fu_value[grant_id*XLEN +: XLEN];
      win_rob    = fu_rob_idx[grant_id*ROB_W +: ROB_W];
    end
`endif
    push = '0;
    pop  = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      pop[i]  = grant_valid && (grant_id == ID_W'(i)) && !win_bypass;
      push[i] = fu_valid[i] && fu_ready[i] &&
                !(grant_valid && (grant_id == ID_W'(i)) && win_bypass);
    end
  end

  always_ff @(posedge clock) begin
    if (reset && !squash) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (push[i]) begin
          mem_pr[i][tail[i]]  <= fu_pr_idx[i*PR_W +: PR_W];
          mem_val[i][tail[i]] <= fu_value[i*XLEN +: XLEN];
          mem_rob[i][tail[i]] <= fu_rob_idx[i*ROB_W +: ROB_W];
        end
      end
    end
  end

  // Squash empties every FIFO but keeps rr_ptr so fairness survives a flush.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_FU; i++) begin
        count[i] <= '0;
        head[i]  <= '0;
        tail[i]  <= '0;
      end
      rr_ptr      <= '0;
      cdb_valid   <= 1'b0;
      cdb_pr_idx  <= '0;
      cdb_value   <= '0;
      cdb_rob_idx <= '0;
      cdb_fu_id   <= '0;
    end else if (squash) begin
      for (int i = 0; i < NUM_FU; i++) begin
        count[i] <= '0;
        head[i]  <= '0;
        tail[i]  <= '0;
      end
      cdb_valid <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (push[i]) tail[i] <= tail[i] + PTR_W'(1);
        if (pop[i])  head[i] <= head[i] + PTR_W'(1);
        count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
      cdb_valid <= grant_valid;
      if (grant_valid) begin
        cdb_pr_idx  <= win_pr;
        cdb_value   <= win_val;
        cdb_rob_idx <= win_rob;
        cdb_fu_id   <= grant_id;
        rr_ptr      <= (grant_id == ID_W'(NUM_FU-1)) ? '0 : grant_id + ID_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fu_complete_arbiter.sv
// Directed bench for fu_complete_arbiter (default build, bypass disabled).
module tb_fu_complete_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        squash;
  logic [5:0]  fu_valid;
  logic [35:0] fu_pr_idx;
  logic [191:0] fu_value;
  logic [29:0] fu_rob_idx;
  logic [5:0]  fu_ready;
  logic        cdb_valid;
  logic [5:0]  cdb_pr_idx;
  logic [31:0] cdb_value;
  logic [4:0]  cdb_rob_idx;
  logic [2:0]  cdb_fu_id;
  logic [11:0] occupancy;

  int compared   = 0;
  int mismatched = 0;

  fu_complete_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .squash      (squash),
    .fu_valid    (fu_valid),
    .fu_pr_idx   (fu_pr_idx),
    .fu_value    (fu_value),
    .fu_rob_idx  (fu_rob_idx),
    .fu_ready    (fu_ready),
    .cdb_valid   (cdb_valid),
    .cdb_pr_idx  (cdb_pr_idx),
    .cdb_value   (cdb_value),
    .cdb_rob_idx (cdb_rob_idx),
    .cdb_fu_id   (cdb_fu_id),
    .occupancy   (occupancy)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic applyStimulus();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clearInputs();
    fu_valid   = '0;
    fu_pr_idx  = '0;
    fu_value   = '0;
    fu_rob_idx = '0;
  endtask

  task automatic setPacket(input int fu, input logic [5:0] pr, input logic [31:0] val, input logic [4:0] rob);
    fu_valid[fu]              = 1'b1;
    fu_pr_idx[fu*6 +: 6]      = pr;
    fu_value[fu*32 +: 32]     = val;
    fu_rob_idx[fu*5 +: 5]     = rob;
  endtask

  task automatic checkCdb(input string tag, input logic [2:0] id, input logic [31:0] val);
    checkOutput({tag, "_valid"}, 64'(cdb_valid), 64'd1);
    checkOutput({tag, "_fu_id"}, 64'(cdb_fu_id), 64'(id));
    checkOutput({tag, "_value"}, 64'(cdb_value), 64'(val));
  endtask

  initial begin
    reset  = 1'b0;
    squash = 1'b0;
    clearInputs();

    // Reset, then a single push from FU 0
    applyStimulus();
    applyStimulus();
    checkOutput("rst_ready", 64'(fu_ready), 64'h00);
    checkOutput("rst_valid", 64'(cdb_valid), 64'd0);
    checkOutput("rst_occ", 64'(occupancy), 64'h000);
    checkOutput("rst_pr", 64'(cdb_pr_idx), 64'd0);
    checkOutput("rst_value", 64'(cdb_value), 64'd0);
    reset = 1'b1;
    #1;
    checkOutput("rel_ready", 64'(fu_ready), 64'h3f);
    setPacket(0, 6'd5, 32'hDEAD_BEEF, 5'd3);
    applyStimulus();
    clearInputs();
    checkOutput("single_occ", 64'(occupancy), 64'h001);
    checkOutput("single_early", 64'(cdb_valid), 64'd0);
    applyStimulus();
    checkCdb("single", 3'd0, 32'hDEAD_BEEF);
    checkOutput("single_pr", 64'(cdb_pr_idx), 64'd5);
    checkOutput("single_rob", 64'(cdb_rob_idx), 64'd3);
    checkOutput("single_ready", 64'(fu_ready), 64'h3f);
    applyStimulus();
    checkOutput("single_drop", 64'(cdb_valid), 64'd0);

    // Fairness: everyone pushes once after a fresh reset
    reset = 1'b0;
    applyStimulus();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) setPacket(i, 6'(10 + i), 32'h100 + i, 5'(i));
    applyStimulus();
    clearInputs();
    checkOutput("fair_occ", 64'(occupancy), 64'h555);
    checkOutput("fair_early", 64'(cdb_valid), 64'd0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus();
      checkCdb($sformatf("fair%0d", k), 3'(k), 32'h100 + k);
      checkOutput($sformatf("fair%0d_pr", k), 64'(cdb_pr_idx), 64'(10 + k));
    end
    applyStimulus();
    checkOutput("fair_drop", 64'(cdb_valid), 64'd0);

    // Back-pressure on FU 2 while FUs 0 and 1 compete
    setPacket(0, 6'd1, 32'hA0, 5'd0);
    setPacket(1, 6'd2, 32'hB0, 5'd1);
    setPacket(2, 6'd3, 32'hC0, 5'd2);
    applyStimulus();
    setPacket(0, 6'd1, 32'hA1, 5'd0);
    setPacket(1, 6'd2, 32'hB1, 5'd1);
    setPacket(2, 6'd3, 32'hC1, 5'd2);
    applyStimulus();
    clearInputs();
    setPacket(2, 6'd3, 32'hC2, 5'd2);
    checkCdb("bp_e2", 3'd0, 32'hA0);
    checkOutput("bp_e2_occ", 64'(occupancy), 64'h029);
    checkOutput("bp_e2_ready", 64'(fu_ready), 64'h39);
    applyStimulus();
    checkCdb("bp_e3", 3'd1, 32'hB0);
    checkOutput("bp_e3_ready", 64'(fu_ready), 64'h3b);
    applyStimulus();
    checkCdb("bp_e4", 3'd2, 32'hC0);
    checkOutput("bp_e4_ready", 64'(fu_ready), 64'h3f);
    applyStimulus();
    clearInputs();
    checkCdb("bp_e5", 3'd0, 32'hA1);
    applyStimulus();
    checkCdb("bp_e6", 3'd1, 32'hB1);
    applyStimulus();
    checkCdb("bp_e7", 3'd2, 32'hC1);
    applyStimulus();
    checkCdb("bp_e8", 3'd2, 32'hC2);
    checkOutput("bp_e8_occ", 64'(occupancy), 64'h000);
    applyStimulus();
    checkOutput("bp_drop", 64'(cdb_valid), 64'd0);

    // Squash with buffered FIFOs 1/4 and a same-cycle push from FU 3
    setPacket(1, 6'd7, 32'hD0, 5'd7);
    setPacket(4, 6'd8, 32'hE0, 5'd8);
    applyStimulus();
    checkOutput("sq_fill_occ", 64'(occupancy), 64'h104);
    setPacket(1, 6'd7, 32'hD1, 5'd7);
    setPacket(4, 6'd8, 32'hE1, 5'd8);
    applyStimulus();
    checkCdb("sq_pre", 3'd4, 32'hE0);
    checkOutput("sq_pre_occ", 64'(occupancy), 64'h108);
    squash = 1'b1;
    setPacket(3, 6'd9, 32'hF3, 5'd9);
    applyStimulus();
    squash = 1'b0;
    clearInputs();
    checkOutput("sq_occ", 64'(occupancy), 64'h000);
    checkOutput("sq_valid", 64'(cdb_valid), 64'd0);
    applyStimulus();
    checkOutput("sq_after_valid", 64'(cdb_valid), 64'd0);
    setPacket(0, 6'd11, 32'h60, 5'd11);
    setPacket(5, 6'd12, 32'h65, 5'd12);
    applyStimulus();
    clearInputs();
    applyStimulus();
    checkCdb("sq_rr_keep", 3'd5, 32'h65);
    applyStimulus();
    checkCdb("sq_rr_next", 3'd0, 32'h60);
    applyStimulus();
    checkOutput("sq_drop", 64'(cdb_valid), 64'd0);

    // Reset in the middle of traffic
    for (int i = 0; i < 6; i++) setPacket(i, 6'(20 + i), 32'h700 + i, 5'(i));
    applyStimulus();
    clearInputs();
    applyStimulus();
    checkCdb("mid_pre", 3'd1, 32'h701);
    checkOutput("mid_pre_occ", 64'(occupancy), 64'h551);
    reset = 1'b0;
    applyStimulus();
    checkOutput("mid_valid", 64'(cdb_valid), 64'd0);
    checkOutput("mid_pr", 64'(cdb_pr_idx), 64'd0);
    checkOutput("mid_value", 64'(cdb_value), 64'd0);
    checkOutput("mid_rob", 64'(cdb_rob_idx), 64'd0);
    checkOutput("mid_fu_id", 64'(cdb_fu_id), 64'd0);
    checkOutput("mid_occ", 64'(occupancy), 64'h000);
    checkOutput("mid_ready", 64'(fu_ready), 64'h00);
    reset = 1'b1;
    setPacket(3, 6'd30, 32'h803, 5'd3);
    setPacket(5, 6'd31, 32'h805, 5'd5);
    applyStimulus();
    clearInputs();
    checkOutput("mid_rel_occ", 64'(occupancy), 64'h440);
    applyStimulus();
    checkCdb("mid_first", 3'd3, 32'h803);
    applyStimulus();
    checkCdb("mid_second", 3'd5, 32'h805);
    applyStimulus();
    checkOutput("mid_drop", 64'(cdb_valid), 64'd0);

    // FU 0 streams alone: push and pop every cycle
    for (int k = 1; k <= 10; k++) begin
      setPacket(0, 6'd40, 32'h5000 + k, 5'(k));
      applyStimulus();
      checkOutput($sformatf("stream%0d_occ", k), 64'(occupancy[1:0]), 64'd1);
      checkOutput($sformatf("stream%0d_ready", k), 64'(fu_ready[0]), 64'd1);
      if (k >= 2) checkCdb($sformatf("stream%0d", k), 3'd0, 32'h5000 + k - 1);
    end
    clearInputs();
    applyStimulus();
    checkCdb("stream_last", 3'd0, 32'h500A);
    checkOutput("stream_last_occ", 64'(occupancy), 64'h000);
    applyStimulus();
    checkOutput("stream_drop", 64'(cdb_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fu_complete_arbiter.md
Name: fu_complete_arbiter

Overview:
- Receiving end of the functional-unit completion interface.
- Accepts one completion packet per FU per cycle through valid/ready handshakes and buffers each FU's results in a private 2-entry FIFO.
- Arbitrates round-robin among non-empty FIFOs and broadcasts one registered result per cycle on the CDB toward ROB, RS wakeup and PRF.
- Back-pressure via fu_ready replaces per-FU stall logic inside the FU cluster.

Parameters:
- NUM_FU, 6, number of FU completion ports (index 0 = lowest).
- XLEN, 32, result value width.
- PR_W, 6, physical-register index width.
- ROB_W, 5, ROB index width.
- FIFO_DEPTH, 2, entries per FU FIFO (power of 2, >=2).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- squash  in  1  synchronous flush of all buffered completions.
- fu_valid  in  NUM_FU  per-FU completion request.
- fu_pr_idx  in  NUM_FU*PR_W  per-FU destination PR, FU i at slice i.
- fu_value  in  NUM_FU*XLEN  per-FU result.
- fu_rob_idx  in  NUM_FU*ROB_W  per-FU ROB tag.
- fu_ready  out  NUM_FU  FIFO i can accept this cycle.
- cdb_valid  out  1  broadcast valid.
- cdb_pr_idx  out  PR_W  broadcast PR index.
- cdb_value  out  XLEN  broadcast value.
- cdb_rob_idx  out  ROB_W  broadcast ROB tag.
- cdb_fu_id  out  $clog2(NUM_FU)  source FU of the broadcast.
- occupancy  out  NUM_FU*2  per-FU FIFO count (width 2 for default depth; generally $clog2(FIFO_DEPTH)+1).

Behaviour:
- Reset (reset==0 at posedge):
  - all FIFO counts, head and tail pointers = 0;
  - rr_ptr = 0;
  - cdb_valid = 0; all cdb_* data = 0;
  - occupancy = 0.
- While reset is low, fu_ready = 0. In the first cycle after release, all fu_ready = 1.
- fu_ready[i] = (count[i] != FIFO_DEPTH) and reset high. It depends only on registered state, so there is no combinational path from fu_valid to fu_ready.
- Push: FU i is written at the posedge when fu_valid[i] & fu_ready[i]. fu_valid without fu_ready is ignored; the FU must hold the packet.
- Arbitration, once per cycle, combinational on registered counts:
  - search FIFOs starting at rr_ptr, wrapping modulo NUM_FU;
  - first non-empty FIFO wins;
  - winner's head is popped at the posedge and registered onto cdb_*;
  - rr_ptr <= (winner+1) mod NUM_FU;
  - no winner: cdb_valid <= 0, data outputs hold, rr_ptr holds.
- Latency (bypass disabled): packet accepted at edge E0 into an empty FIFO with no competitors appears on the CDB after edge E1.
- Throughput: 1 broadcast per cycle total.
- Simultaneous push and pop on the same FIFO: count unchanged, ordering preserved.
- Push into a FIFO with count == FIFO_DEPTH-1 while it is also popped is legal; that FIFO's ready is 1 in the following cycle.
- Per-FU order is strictly FIFO. No ordering is guaranteed across FUs.
- squash==1 at posedge:
  - all counts and pointers clear;
  - same-cycle pushes are dropped;
  - cdb_valid <= 0;
  - rr_ptr unchanged.
- squash and reset low together: reset dominates (identical result).
- Pointer wrap: head and tail pointers wrap modulo FIFO_DEPTH. count is kept separately, which distinguishes full from empty.

Optional Feature:
- Macro: FU_COMPLETE_ARBITER_BYPASS_EN.
- When defined:
  - a FIFO with count==0 whose FU presents fu_valid & fu_ready counts as a candidate in the same cycle's arbitration;
  - if it wins, the incoming packet goes straight to cdb_* at that posedge and is not written into the FIFO (latency 1 edge);
  - a bypass candidate ranks identically to a non-empty FIFO at the same index;
  - squash suppresses bypass.
- When undefined: arbitration considers only registered FIFO contents; latency is 2 edges.

Test Plan:
- Reset then single push: reset low 2 cycles, then fu_valid=6'b000001, pr=5, value=32'hDEAD_BEEF, rob=3 for 1 cycle → cdb_valid=1 with pr=5, value=DEADBEEF, rob=3, fu_id=0 after the next edge (same edge with BYPASS_EN); fu_ready=6'b111111 throughout after reset.
- Fairness: all 6 FUs push one packet in the same cycle → cdb_fu_id sequence 0,1,2,3,4,5 on 6 consecutive cycles; cdb_valid then drops to 0.
- Back-pressure: FU 2 pushes on 3 consecutive cycles while FUs 0,1 are kept busy → fu_ready[2]=0 once count=2, third packet held and accepted later, FU 2 values broadcast in push order.
- Squash: fill FIFOs 1 and 4 to count 2, assert squash with fu_valid[3]=1 → occupancy=0 and cdb_valid=0 next cycle; FU 3's packet never appears on the CDB.
- Reset mid-operation: reset low while 5 entries are buffered and cdb_valid=1 → next cycle all outputs 0 and rr_ptr=0; first grant after release goes to the lowest-index requester.
- Simultaneous push/pop: FU 0 sole requester, pushes every cycle for 10 cycles → occupancy[0] stays ≤1, fu_ready[0] stays 1, 10 consecutive broadcasts in order.
